ps2_keyboard_controller: RTL and testbench
==========================================

# ps2_keyboard_controller

Synchronous PS/2 keyboard front end that replaces edge-clocked capture on `PS2_CLK` with logic clocked entirely by `CLOCK_50`. The block sequences PS/2 frame reception, checks parity and stop bits, and recovers from stalled frames with a timeout. It folds Set-2 `E0`/`F0` prefix bytes into single key events and buffers those events in a FIFO that the CPU-side bus logic drains with a pop handshake.

## Interface
- `FIFO_DEPTH`, default 8: event FIFO entries; must be a power of 2, ≥2.
- `TIMEOUT_CYCLES`, default 50000: `CLOCK_50` cycles without a PS/2 falling edge before a partial frame is abandoned (1 ms at 50 MHz).

- `CLOCK_50` input 1: sole clock, rising edge.
- `RESET_N` input 1: reset, asynchronous assert, active-low.
- `PS2_CLK` input 1: raw keyboard clock, asynchronous.
- `PS2_DAT` input 1: raw keyboard data, asynchronous.
- `rd_en` input 1: pops the head event when `key_valid` is 1.
- `clear_errors` input 1: clears both sticky error flags.
- `key_code` output 8: head event scancode (show-ahead).
- `key_extended` output 1: head event was preceded by `E0`.
- `key_release` output 1: head event was preceded by `F0`.
- `key_valid` output 1: FIFO non-empty.
- `frame_error` output 1: sticky; a frame failed its parity or stop check.
- `overflow` output 1: sticky; an event was dropped because the FIFO was full.

## Operation
- Reset: FSM IDLE, prefix flags 0, FIFO empty, timeout counter 0. All outputs 0. A frame in progress when reset asserts is discarded.
- Input conditioning: `PS2_CLK` and `PS2_DAT` each pass through a 2-flop synchronizer. A falling edge is `clk_sync_prev==1 && clk_sync==0`. All bit sampling uses `dat_sync` in the falling-edge cycle.
- Frame FSM, advanced only on falling edges:
  - IDLE -> DATA when `dat_sync==0` (start bit). When `dat_sync==1`, stay in IDLE and ignore the edge.
  - DATA shifts 8 bits LSB-first, with a bit counter running 0..7. It moves to PARITY after bit 7.
  - PARITY captures the parity bit -> STOP.
  - STOP: the frame is good when XOR(data[7:0], parity)==1 (odd parity) and `dat_sync==1`. A good frame emits a one-cycle byte strobe. A bad frame sets `frame_error` and emits no strobe. The FSM goes to IDLE in either case.
- Timeout: the counter clears on every falling edge and whenever the FSM is in IDLE. Outside IDLE it increments each cycle. On reaching `TIMEOUT_CYCLES` the FSM goes to IDLE, discards the partial byte and sets no error.
- Prefix decode, on each byte strobe:
  - `E0` sets ext_pending.
  - `F0` sets rel_pending.
  - Any other byte pushes {ext_pending, rel_pending, byte} and clears both flags.
  - Prefixes accumulate in any order. A repeated prefix is idempotent.
- FIFO: 10-bit entries. Occupancy counter is clog2(FIFO_DEPTH)+1 bits; read and write pointers wrap modulo FIFO_DEPTH.
  - Pop occurs when `rd_en && key_valid`. `rd_en` while empty is ignored.
  - A push while full without a same-cycle pop drops the event and sets `overflow`. The prefix flags still clear.
  - A push and pop in the same cycle while full: both are accepted, occupancy is unchanged and `overflow` is not set.
  - A push and pop in the same cycle while empty: cannot occur, because a pop needs `key_valid`.
- Sticky flags: `clear_errors` clears both. If a set and a clear occur in the same cycle, the set wins.

## Timing
- Event latency: `key_valid` rises 4 `CLOCK_50` edges after the edge on which the synchronizer's first flop captures the stop-bit `PS2_CLK` low:
  - sync2;
  - edge detect/FSM;
  - byte strobe register;
  - FIFO write.
- `key_code`, `key_extended` and `key_release` are valid in the same cycle `key_valid` is 1, and stay stable until popped.
- Pop: after an edge with `rd_en && key_valid`, the next entry appears on the outputs the following cycle. When that pop empties the FIFO, `key_valid` is 0 the following cycle.
- `frame_error` sets 1 cycle after the STOP-state falling edge. `overflow` sets on the cycle the dropped write would have occurred.
- Minimum PS/2 high or low phase handled: 3 `CLOCK_50` cycles. Shorter pulses may be missed.

## Test plan
- Reset, then send frame `1C` (start 0, data LSB-first, parity 0, stop 1) -> `key_valid` 1 with `key_code`=1C, ext=0, rel=0 exactly 4 cycles after stop-edge capture; `rd_en` pulse -> `key_valid` 0.
- Send `E0 F0 74` -> one event with code=74, ext=1, rel=1. Send `F0 1C` -> one event with code=1C, ext=0, rel=1.
- Send `1C` with parity bit 1, then `32` with stop bit 0 -> no events, `frame_error`=1; `clear_errors` -> 0.
- Send start plus 4 data bits, stall for `TIMEOUT_CYCLES`+1 (bench uses 100), then send `1C` -> exactly one event `1C`, `frame_error`=0.
- With `FIFO_DEPTH`=4 and no pops, send 5 codes `15 1D 24 2D 2C` -> four events `15 1D 24 2D` read in order, `overflow`=1. Refill to 4 entries and pop in the same cycle as a 5th push -> no overflow, order preserved.
- Assert `RESET_N` low mid-frame and with 3 events queued -> all outputs 0 immediately. After release, a fresh `1C` frame yields exactly one event.

Source files
------------

// File: rtl/ps2_keyboard_controller.sv
// rtl/ps2_keyboard_controller.sv - PS/2 keyboard receiver with Set-2 prefix folding and event FIFO
module ps2_keyboard_controller #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  input  logic       rd_en,
  input  logic       clear_errors,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_release,
  output logic       key_valid,
  output logic       frame_error,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] FIFO_FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [7:0]    CODE_EXT      = 8'hE0;
  localparam logic [7:0]    CODE_REL      = 8'hF0;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // synchronizer and edge-detect state
  logic clk_meta, clk_sync, clk_sync_prev;
  logic dat_meta, dat_sync;
  logic ps2_fall;

  // frame FSM state
  state_t     state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shift_reg, shift_nxt;
  logic       parity_bit, parity_nxt;
  logic       strobe_nxt, ferr_set;
  logic       timed_out;
  logic [TW-1:0] timeout_cnt;

  // byte strobe stage
  logic       byte_strobe;
  logic [7:0] byte_data;

  // prefix decode stage
  logic       ext_pending, rel_pending;
  logic       push_req;
  logic [9:0] push_data;

  // event FIFO
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_full, pop, wr_ok, ovf_set;
  logic [9:0]    head;

  assign ps2_fall = clk_sync_prev & ~clk_sync;

  // two-flop synchronizers; idle-high reset values so reset release never looks like an edge
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      clk_meta      <= 1'b1;
      clk_sync      <= 1'b1;
      clk_sync_prev <= 1'b1;
      dat_meta      <= 1'b1;
      dat_sync      <= 1'b1;
    end else begin
      clk_meta      <= PS2_CLK;
      clk_sync      <= clk_meta;
      clk_sync_prev <= clk_sync;
      dat_meta      <= PS2_DAT;
      dat_sync      <= dat_meta;
    end
  end

  assign timed_out = (state != IDLE) && !ps2_fall && (timeout_cnt == TIMEOUT_LIMIT);

  // stall counter: runs only while a frame is open and no PS/2 edge arrives
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      timeout_cnt <= '0;
    end else if (state == IDLE || ps2_fall || timed_out) begin
      timeout_cnt <= '0;
    end else begin
      timeout_cnt <= timeout_cnt + TW'(1);
    end
  end

  // frame FSM next-state: only falling edges advance it, the stall timer can abandon it
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift_reg;
    parity_nxt  = parity_bit;
    strobe_nxt  = 1'b0;
    ferr_set    = 1'b0;
    if (ps2_fall) begin
      case (state)
        IDLE: begin
          if (!dat_sync) begin
            state_nxt   = DATA;
            bit_cnt_nxt = 3'd0;
          end
        end
        DATA: begin
          shift_nxt   = {dat_sync, shift_reg[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_nxt = PARITY;
          end
        end
        PARITY: begin
          parity_nxt = dat_sync;
          state_nxt  = STOP;
        end
        STOP: begin
          state_nxt = IDLE;
          if ((^shift_reg ^ parity_bit) && dat_sync) begin
            strobe_nxt = 1'b1;
          end else begin
            ferr_set = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else if (timed_out) begin
      state_nxt = IDLE;
    end
  end

  // frame FSM registers and the registered byte strobe
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      shift_reg   <= 8'h00;
      parity_bit  <= 1'b0;
      byte_strobe <= 1'b0;
      byte_data   <= 8'h00;
    end else begin
      state       <= state_nxt;
      bit_cnt     <= bit_cnt_nxt;
      shift_reg   <= shift_nxt;
      parity_bit  <= parity_nxt;
      byte_strobe <= strobe_nxt;
      if (strobe_nxt) begin
        byte_data <= shift_reg;
      end
    end
  end

  // sticky frame error; a new failure outranks a simultaneous clear
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      frame_error <= 1'b0;
    end else begin
      frame_error <= ferr_set | (frame_error & ~clear_errors);
    end
  end

  // fold E0/F0 prefixes into flags and issue one push per real scancode
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      ext_pending <= 1'b0;
      rel_pending <= 1'b0;
      push_req    <= 1'b0;
      push_data   <= 10'h000;
    end else begin
      push_req <= 1'b0;
      if (byte_strobe) begin
        if (byte_data == CODE_EXT) begin
          ext_pending <= 1'b1;
        end else if (byte_data == CODE_REL) begin
          rel_pending <= 1'b1;
        end else begin
          push_req    <= 1'b1;
          push_data   <= {ext_pending, rel_pending, byte_data};
          ext_pending <= 1'b0;
          rel_pending <= 1'b0;
        end
      end
    end
  end

  assign fifo_full = (count == FIFO_FULL_CNT);
  assign key_valid = (count != '0);
  assign pop       = rd_en & key_valid;
  assign wr_ok     = push_req & (~fifo_full | pop);
  assign ovf_set   = push_req & fifo_full & ~pop;

  // FIFO pointers and occupancy; a full FIFO still accepts a write that coincides with a pop
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are only visible through the valid-gated head
  always_ff @(posedge CLOCK_50) begin
    if (wr_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // sticky overflow; a new drop outranks a simultaneous clear
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      overflow <= 1'b0;
    end else begin
      overflow <= ovf_set | (overflow & ~clear_errors);
    end
  end

  // show-ahead head entry, forced to zero when the FIFO is empty
  always_comb begin
    head         = mem[rd_ptr];
    key_code     = 8'h00;
    key_extended = 1'b0;
    key_release  = 1'b0;
    if (key_valid) begin
      key_code     = head[7:0];
      key_extended = head[9];
      key_release  = head[8];
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_controller.sv
// tb/tb_ps2_keyboard_controller.sv - scoreboard bench for ps2_keyboard_controller
module tb_ps2_keyboard_controller;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       RESET_N, PS2_CLK, PS2_DAT, rd_en, clear_errors;
  logic [7:0] key_code;
  logic       key_extended, key_release, key_valid, frame_error, overflow;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int capture_cyc = -1000;
  int rise_cyc    = -1000;
  bit pop_en  = 1'b0;
  bit arm_pop = 1'b0;
  logic [9:0] exp_q [$];

  ps2_keyboard_controller #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(100)) dut (
    .CLOCK_50(clk), .RESET_N(RESET_N), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .rd_en(rd_en), .clear_errors(clear_errors), .key_code(key_code),
    .key_extended(key_extended), .key_release(key_release), .key_valid(key_valid),
    .frame_error(frame_error), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // monitor: compares the head against the scoreboard whenever it pops
  initial begin
    logic [9:0] exp_e;
    logic       prev_kv;
    prev_kv = 1'b0;
    rd_en   = 1'b0;
    forever begin
      @(negedge clk);
      if (key_valid && !prev_kv) rise_cyc = cyc;
      prev_kv = key_valid;
      if (key_valid && (pop_en || (arm_pop && cyc == capture_cyc + 3))) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event got=%0h exp=none", {key_extended, key_release, key_code});
        end else begin
          exp_e = exp_q.pop_front();
          if ({key_extended, key_release, key_code} !== exp_e) begin
            fails++;
            $display("FAIL event got=%0h exp=%0h", {key_extended, key_release, key_code}, exp_e);
          end
        end
        rd_en = 1'b1;
      end else begin
        rd_en = 1'b0;
      end
    end
  end

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      PS2_DAT = bits[i];
      repeat (HALF) @(negedge clk);
      PS2_CLK = 1'b0;
      if (i == 10) capture_cyc = cyc + 1;
      repeat (HALF) @(negedge clk);
      PS2_CLK = 1'b1;
    end
    PS2_DAT = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] code, input logic par_flip, input logic stop);
    logic [10:0] bits;
    bits = {stop, (~^code) ^ par_flip, code, 1'b0};
    send_bits(bits, 11);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 800) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    check({name, "_valid_low"}, key_valid, 1'b0);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_errors = 1'b1;
    @(negedge clk);
    clear_errors = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] codes_a [5];
    logic [7:0] codes_b [5];
    codes_a = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    codes_b = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
    RESET_N = 1'b0; PS2_CLK = 1'b1; PS2_DAT = 1'b1; clear_errors = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_outputs", {key_code, key_extended, key_release, key_valid, frame_error, overflow}, 0);
    RESET_N = 1'b1;
    repeat (4) @(negedge clk);

    // single make code with latency measurement
    pop_en = 1'b1;
    exp_q.push_back({2'b00, 8'h1C});
    send_frame(8'h1C, 1'b0, 1'b1);
    wait_drain("t1");
    check("t1_latency", rise_cyc - capture_cyc, 4);

    // prefix folding
    exp_q.push_back({2'b11, 8'h74});
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h74, 1'b0, 1'b1);
    exp_q.push_back({2'b01, 8'h1C});
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    wait_drain("t2");
    check("t2_no_frame_error", frame_error, 1'b0);

    // parity and stop errors
    send_frame(8'h1C, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check("t3_parity_error", frame_error, 1'b1);
    pulse_clear();
    check("t3_clear_1", frame_error, 1'b0);
    send_frame(8'h32, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("t3_stop_error", frame_error, 1'b1);
    check("t3_no_event", key_valid, 1'b0);
    pulse_clear();
    check("t3_clear_2", frame_error, 1'b0);

    // stalled partial frame then a clean frame
    send_bits(11'b000_0001_1010, 5);
    repeat (200) @(negedge clk);
    exp_q.push_back({2'b00, 8'h1C});
    send_frame(8'h1C, 1'b0, 1'b1);
    wait_drain("t4");
    check("t4_no_frame_error", frame_error, 1'b0);

    // overflow with no pops
    pop_en = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(codes_a[i], 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check("t5_overflow_set", overflow, 1'b1);
    check("t5_full_valid", key_valid, 1'b1);
    for (int i = 0; i < 4; i++) exp_q.push_back({2'b00, codes_a[i]});
    pop_en = 1'b1;
    wait_drain("t5a");
    check("t5_overflow_sticky", overflow, 1'b1);
    pulse_clear();
    check("t5_overflow_clear", overflow, 1'b0);

    // full FIFO: push and pop in the same cycle
    pop_en = 1'b0;
    for (int i = 0; i < 5; i++) exp_q.push_back({2'b00, codes_b[i]});
    for (int i = 0; i < 4; i++) send_frame(codes_b[i], 1'b0, 1'b1);
    arm_pop = 1'b1;
    send_frame(codes_b[4], 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    arm_pop = 1'b0;
    check("t5_simul_no_overflow", overflow, 1'b0);
    check("t5_simul_one_popped", exp_q.size(), 4);
    pop_en = 1'b1;
    wait_drain("t5b");

    // reset mid-frame with events queued and an error pending
    pop_en = 1'b0;
    for (int i = 0; i < 3; i++) send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h32, 1'b0, 1'b0);
    send_bits(11'b000_0011_1000, 4);
    @(negedge clk);
    PS2_CLK = 1'b0;
    repeat (HALF) @(negedge clk);
    RESET_N = 1'b0;
    #1;
    check("t6_reset_outputs", {key_code, key_extended, key_release, key_valid, frame_error, overflow}, 0);
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    repeat (4) @(negedge clk);
    RESET_N = 1'b1;
    repeat (4) @(negedge clk);
    pop_en = 1'b1;
    exp_q.push_back({2'b00, 8'h1C});
    send_frame(8'h1C, 1'b0, 1'b1);
    wait_drain("t6");
    repeat (50) @(negedge clk);
    check("t6_no_extra", key_valid, 1'b0);
    check("t6_no_frame_error", frame_error, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
